// File: rtl/serial_port_transmitter.sv
// 8N1 serial transmitter on the PicoBlaze port bus: CPU byte writes queue in a small FIFO and
// are shifted out LSB first; a status byte reports full, empty, busy and sticky overflow.
module serial_port_transmitter #(
   parameter int unsigned CLOCKS_PER_BIT  = 500,
   parameter int unsigned FIFO_DEPTH_LOG2 = 2,
   parameter logic [7:0]  DATA_PORT_ID    = 8'h83,
   parameter logic [7:0]  STATUS_PORT_ID  = 8'h84
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] cpuPortId,
   input  logic       cpuWriteStrobe,
   input  logic [7:0] cpuWriteData,
   input  logic       cpuReadStrobe,
   output logic [7:0] statusReadData,
   output logic       serialPortDataOut
);

   localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [15:0] LAST_CYCLE = 16'(CLOCKS_PER_BIT - 1);
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = (FIFO_DEPTH_LOG2)'(1);
   localparam logic [FIFO_DEPTH_LOG2:0] CNT_ONE = (FIFO_DEPTH_LOG2 + 1)'(1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

   state_t                     state;
   logic [7:0]                 fifo_mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic [FIFO_DEPTH_LOG2:0]   count;
   logic [7:0]                 shift;
   logic [2:0]                 bit_cnt;
   logic [15:0]                cycle_cnt;
   logic                       overflow;

   logic fifo_full;
   logic fifo_empty;
   logic data_write;
   logic status_read;
   logic push;
   logic pop;
   logic bit_done;

   // Occupancy never exceeds DEPTH, so its MSB alone marks full.
   assign fifo_full   = count[FIFO_DEPTH_LOG2];
   assign fifo_empty  = (count == '0);
   assign data_write  = cpuWriteStrobe && (cpuPortId == DATA_PORT_ID);
   assign status_read = cpuReadStrobe && (cpuPortId == STATUS_PORT_ID);
   assign push        = data_write && !fifo_full;
   assign bit_done    = (cycle_cnt == LAST_CYCLE);
   assign pop         = !fifo_empty && ((state == StIdle) || ((state == StStop) && bit_done));

   assign statusReadData = {4'b0000, overflow, (state != StIdle), fifo_empty, fifo_full};

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= cpuWriteData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (!push && pop) begin
            count <= count - CNT_ONE;
         end
         // A dropped write beats a coincident clearing read.
         if (data_write && fifo_full) begin
            overflow <= 1'b1;
         end else if (status_read) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= StIdle;
         serialPortDataOut <= 1'b1;
         shift             <= '0;
         bit_cnt           <= '0;
         cycle_cnt         <= '0;
      end else begin
         cycle_cnt <= bit_done ? '0 : cycle_cnt + 16'd1;
         unique case (state)
            StIdle: begin
               cycle_cnt <= '0;
               if (pop) begin
                  shift             <= fifo_mem[rd_ptr];
                  serialPortDataOut <= 1'b0;
                  state             <= StStart;
               end
            end
            StStart: begin
               if (bit_done) begin
                  serialPortDataOut <= shift[0];
                  shift             <= shift >> 1;
                  bit_cnt           <= '0;
                  state             <= StData;
               end
            end
            StData: begin
               if (bit_done) begin
                  if (bit_cnt == 3'd7) begin
                     serialPortDataOut <= 1'b1;
                     state             <= StStop;
                  end else begin
                     serialPortDataOut <= shift[0];
                     shift             <= shift >> 1;
                     bit_cnt           <= bit_cnt + 3'd1;
                  end
               end
            end
            StStop: begin
               // Chain straight into the next start bit so queued frames leave no idle gap.
               if (bit_done) begin
                  if (pop) begin
                     shift             <= fifo_mem[rd_ptr];
                     serialPortDataOut <= 1'b0;
                     state             <= StStart;
                  end else begin
                     state <= StIdle;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_port_transmitter.sv
// Directed bench for serial_port_transmitter: status vectors from tables, frames recovered by a
// mid-bit sampling receiver and compared against hand-computed 10-bit frames.
module tb_serial_port_transmitter;

   localparam int CPB = 500;

   logic       clk;
   logic       reset;
   logic [7:0] cpuPortId;
   logic       cpuWriteStrobe;
   logic [7:0] cpuWriteData;
   logic       cpuReadStrobe;
   logic [7:0] statusReadData;
   logic       serialPortDataOut;

   serial_port_transmitter #(
      .CLOCKS_PER_BIT (CPB),
      .FIFO_DEPTH_LOG2(2),
      .DATA_PORT_ID   (8'h83),
      .STATUS_PORT_ID (8'h84)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .cpuPortId        (cpuPortId),
      .cpuWriteStrobe   (cpuWriteStrobe),
      .cpuWriteData     (cpuWriteData),
      .cpuReadStrobe    (cpuReadStrobe),
      .statusReadData   (statusReadData),
      .serialPortDataOut(serialPortDataOut)
   );

   typedef struct {
      logic [7:0] port;
      logic       wr;
      logic       rd;
      logic [7:0] data;
      logic [7:0] status;
   } step_t;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;  // bit i = i-th transmitted bit (start, d0..d7, stop)
   } frame_t;

   step_t  t4_steps [13];
   frame_t t3_frames [4];
   frame_t t4_frames [5];

   int tests = 0;
   int fails = 0;
   int unsigned cyc = 0;
   logic [9:0]  rx_q[$];
   int unsigned start_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Receiver: detect start at a negedge, then sample each bit near its middle.
   initial begin : rx_monitor
      logic [9:0]  frame;
      logic        aborted;
      int unsigned start;
      forever begin
         @(negedge clk);
         if (!reset && serialPortDataOut === 1'b0) begin
            start   = cyc;
            aborted = 1'b0;
            for (int b = 0; b < 10; b++) begin
               repeat ((b == 0) ? CPB / 2 : CPB) begin
                  @(negedge clk);
                  if (reset) aborted = 1'b1;
               end
               frame[b] = serialPortDataOut;
            end
            if (!aborted) begin
               rx_q.push_back(frame);
               start_q.push_back(start);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of bus inputs starting at a negedge; returns at the next negedge.
   task automatic put(input logic [7:0] port, input logic wr, input logic rd,
                      input logic [7:0] data);
      cpuPortId      = port;
      cpuWriteStrobe = wr;
      cpuReadStrobe  = rd;
      cpuWriteData   = data;
      @(negedge clk);
   endtask

   task automatic idle();
      put(8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic wait_frames(input int n, input int budget, input string name);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(rx_q.size()), 32'(n));
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (statusReadData !== 8'h02 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(statusReadData), 32'h02);
   endtask

   task automatic check_frames(input frame_t exp [], input string name);
      for (int i = 0; i < exp.size(); i++) begin
         if (i < rx_q.size()) begin
            check($sformatf("%s frame %0d", name, i), 32'(rx_q[i]), 32'(exp[i].frame));
            if (i > 0) begin
               check($sformatf("%s gap %0d", name, i), start_q[i] - start_q[i-1], 32'(10 * CPB));
            end
         end
      end
   endtask

   initial begin
      int lows;

      t3_frames[0] = '{8'h00, 10'h200};
      t3_frames[1] = '{8'h0A, 10'h214};
      t3_frames[2] = '{8'h0F, 10'h21E};
      t3_frames[3] = '{8'h41, 10'h282};

      t4_frames[0] = '{8'hA5, 10'h34A};
      t4_frames[1] = '{8'hFF, 10'h3FE};
      t4_frames[2] = '{8'h3C, 10'h278};
      t4_frames[3] = '{8'h81, 10'h302};
      t4_frames[4] = '{8'h7E, 10'h2FC};

      t4_steps[0]  = '{8'h83, 1'b1, 1'b0, 8'hA5, 8'h00};
      t4_steps[1]  = '{8'h83, 1'b1, 1'b0, 8'hFF, 8'h04};
      t4_steps[2]  = '{8'h83, 1'b1, 1'b0, 8'h3C, 8'h04};
      t4_steps[3]  = '{8'h83, 1'b1, 1'b0, 8'h81, 8'h04};
      t4_steps[4]  = '{8'h83, 1'b1, 1'b0, 8'h7E, 8'h05};
      t4_steps[5]  = '{8'h83, 1'b1, 1'b0, 8'h55, 8'h0D};
      t4_steps[6]  = '{8'h84, 1'b0, 1'b1, 8'h00, 8'h05};
      t4_steps[7]  = '{8'h82, 1'b1, 1'b0, 8'h12, 8'h05};
      t4_steps[8]  = '{8'h83, 1'b1, 1'b1, 8'h99, 8'h0D};
      t4_steps[9]  = '{8'h85, 1'b0, 1'b1, 8'h00, 8'h0D};
      t4_steps[10] = '{8'h84, 1'b1, 1'b1, 8'h77, 8'h05};
      t4_steps[11] = '{8'h83, 1'b1, 1'b0, 8'h66, 8'h0D};
      t4_steps[12] = '{8'h84, 1'b0, 1'b1, 8'h00, 8'h05};

      // 1: reset
      reset          = 1'b1;
      cpuPortId      = 8'h00;
      cpuWriteStrobe = 1'b0;
      cpuReadStrobe  = 1'b0;
      cpuWriteData   = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("reset line", 32'(serialPortDataOut), 32'h1);
         check("reset status", 32'(statusReadData), 32'h02);
      end
      reset = 1'b0;
      idle();
      check("post-reset line", 32'(serialPortDataOut), 32'h1);
      check("post-reset status", 32'(statusReadData), 32'h02);
      put(8'h82, 1'b1, 1'b0, 8'hEE);
      idle();
      check("foreign port write status", 32'(statusReadData), 32'h02);
      check("foreign port write line", 32'(serialPortDataOut), 32'h1);

      // 2: single byte, latency and exact frame length
      rx_q.delete();
      start_q.delete();
      put(8'h83, 1'b1, 1'b0, 8'h41);
      check("t2 accept status", 32'(statusReadData), 32'h00);
      check("t2 accept line", 32'(serialPortDataOut), 32'h1);
      idle();
      check("t2 start line", 32'(serialPortDataOut), 32'h0);
      check("t2 start status", 32'(statusReadData), 32'h06);
      repeat (10 * CPB - 1) @(negedge clk);
      check("t2 last stop cycle status", 32'(statusReadData), 32'h06);
      check("t2 last stop cycle line", 32'(serialPortDataOut), 32'h1);
      @(negedge clk);
      check("t2 end status", 32'(statusReadData), 32'h02);
      wait_frames(1, 10, "t2 frame count");
      if (rx_q.size() > 0) check("t2 frame", 32'(rx_q[0]), 32'h282);

      // 3: four bytes back-to-back, no inter-frame gap
      rx_q.delete();
      start_q.delete();
      for (int i = 0; i < 4; i++) put(8'h83, 1'b1, 1'b0, t3_frames[i].data);
      idle();
      wait_frames(4, 25000, "t3 frame count");
      check_frames(t3_frames, "t3");
      wait_idle(1000, "t3 idle status");

      // 4/5: overfill, overflow set and clear
      rx_q.delete();
      start_q.delete();
      for (int i = 0; i < 13; i++) begin
         put(t4_steps[i].port, t4_steps[i].wr, t4_steps[i].rd, t4_steps[i].data);
         check($sformatf("t4 step %0d status", i), 32'(statusReadData),
               32'(t4_steps[i].status));
      end
      idle();
      wait_frames(5, 27000, "t4 frame count");
      check_frames(t4_frames, "t4");
      wait_idle(1000, "t4 idle status");
      repeat (CPB) @(negedge clk);
      check("t4 no extra frames", 32'(rx_q.size()), 32'd5);

      // 6: reset mid-frame with two bytes queued
      rx_q.delete();
      start_q.delete();
      put(8'h83, 1'b1, 1'b0, 8'h11);
      put(8'h83, 1'b1, 1'b0, 8'h22);
      put(8'h83, 1'b1, 1'b0, 8'h33);
      idle();
      repeat (3 * CPB) @(negedge clk);
      check("t6 queued status", 32'(statusReadData), 32'h04);
      reset = 1'b1;
      @(negedge clk);
      check("t6 reset line", 32'(serialPortDataOut), 32'h1);
      check("t6 reset status", 32'(statusReadData), 32'h02);
      reset = 1'b0;
      lows  = 0;
      repeat (12 * CPB) begin
         @(negedge clk);
         if (serialPortDataOut !== 1'b1) lows++;
      end
      check("t6 line held idle", 32'(lows), 32'd0);
      check("t6 no frames", 32'(rx_q.size()), 32'd0);
      check("t6 final status", 32'(statusReadData), 32'h02);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
